// File: rtl/flash_ctrl_region_arb.sv
// Round-robin arbiter/sequencer sharing the flash op port; each op is checked against the region table.
// Latency: gnt 1 cycle after req sampled; denied done at 2; allowed done at 4 with immediate phy ack/done.
// Backpressure: one op in flight; requesters hold req_i until gnt_o, phy stalls via flash_ack_i/flash_done_i.
// Optional macro FLASH_CTRL_REGION_ARB_TIMEOUT_EN adds a WAIT-state watchdog of TimeoutCyc cycles.
module flash_ctrl_region_arb #(
   parameter int NumReq     = 2,
   parameter int NumRegions = 4,
   parameter int AddrW      = 16,
   parameter int TimeoutCyc = 1023
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq*AddrW-1:0]     addr_i,
   input  logic [NumReq*2-1:0]         op_i,
   output logic [NumReq-1:0]           gnt_o,
   output logic [NumReq-1:0]           done_o,
   output logic                        err_o,
   input  logic                        phase_i,
   input  logic [NumRegions-1:0]       region_en_i,
   input  logic [NumRegions*AddrW-1:0] region_base_i,
   input  logic [NumRegions*AddrW-1:0] region_size_i,
   input  logic [NumRegions*4-1:0]     region_attr_i,
   output logic                        flash_req_o,
   output logic [AddrW-1:0]            flash_addr_o,
   output logic [1:0]                  flash_op_o,
   input  logic                        flash_ack_i,
   input  logic                        flash_done_i,
   input  logic                        flash_err_i
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   if (NumReq < 1 || NumReq > 8 || NumRegions < 1 || NumRegions > 16 ||
       AddrW < 1 || TimeoutCyc < 1) begin : g_bad_param
      $error("flash_ctrl_region_arb: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  ptr_q, winner_q;
   logic [AddrW-1:0] addr_q;
   logic [1:0]       op_q;
   logic             err_q;
   logic [AddrW-1:0] flash_addr_q;
   logic [1:0]       flash_op_q;

   logic             req_any;
   logic             found_hi;
   logic [IdxW-1:0]  sel_hi, sel_lo, sel_idx;
   logic [AddrW-1:0] sel_addr;
   logic [1:0]       sel_op;

   logic             hit;
   logic [3:0]       hit_attr;
   logic [AddrW:0]   base_ext, end_ext;
   logic             perm;
   logic             allowed;
   logic             timeout;

   // Round-robin pick: lowest requester at/after the pointer, else lowest below it
   always_comb begin
      req_any  = |req_i;
      found_hi = 1'b0;
      sel_hi   = '0;
      sel_lo   = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            if (IdxW'(k) >= ptr_q) begin
               found_hi = 1'b1;
               sel_hi   = IdxW'(k);
            end else begin
               sel_lo = IdxW'(k);
            end
         end
      end
      sel_idx  = found_hi ? sel_hi : sel_lo;
      sel_addr = '0;
      sel_op   = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (IdxW'(k) == sel_idx) begin
            sel_addr = addr_i[k*AddrW +: AddrW];
            sel_op   = op_i[k*2 +: 2];
         end
      end
   end

   // Region lookup on the captured address; lowest matching region wins, end computed without wrap
   always_comb begin
      hit      = 1'b0;
      hit_attr = '0;
      base_ext = '0;
      end_ext  = '0;
      for (int r = NumRegions - 1; r >= 0; r--) begin
         base_ext = {1'b0, region_base_i[r*AddrW +: AddrW]};
         end_ext  = base_ext + {1'b0, region_size_i[r*AddrW +: AddrW]};
         if (region_en_i[r] && ({1'b0, addr_q} >= base_ext) && ({1'b0, addr_q} < end_ext)) begin
            hit      = 1'b1;
            hit_attr = region_attr_i[r*4 +: 4];
         end
      end
      perm = 1'b0;
      case (op_q)
         2'd0:    perm = hit_attr[0];
         2'd1:    perm = hit_attr[1];
         2'd2:    perm = hit_attr[2];
         default: perm = 1'b0;
      endcase
      allowed = hit && (hit_attr[3] == phase_i) && perm;
   end

`ifdef FLASH_CTRL_REGION_ARB_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCyc + 1);
   logic [CntW-1:0] cnt_q;

   // Watchdog counts WAIT cycles; held at zero elsewhere so it restarts on every WAIT entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (state_q != WAIT) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout = (state_q == WAIT) && (cnt_q == CntW'(TimeoutCyc - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any) state_d = CHECK;
         CHECK:   state_d = allowed ? ISSUE : RESP;
         ISSUE:   if (flash_ack_i) state_d = WAIT;
         WAIT:    if (flash_done_i || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Captured request, error latch, issued address/op and round-robin pointer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q        <= '0;
         winner_q     <= '0;
         addr_q       <= '0;
         op_q         <= '0;
         err_q        <= 1'b0;
         flash_addr_q <= '0;
         flash_op_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_any) begin
                  winner_q <= sel_idx;
                  addr_q   <= sel_addr;
                  op_q     <= sel_op;
               end
            end
            CHECK: begin
               err_q <= !allowed;
               if (allowed) begin
                  flash_addr_q <= addr_q;
                  flash_op_q   <= op_q;
               end
            end
            WAIT: begin
               // a done arriving on the watchdog limit cycle takes precedence
               if (flash_done_i) begin
                  err_q <= flash_err_i;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end
            end
            RESP: begin
               ptr_q <= (winner_q == IdxW'(NumReq - 1)) ? '0 : winner_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from the state so reset clears them immediately
   always_comb begin
      gnt_o  = '0;
      done_o = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (IdxW'(k) == winner_q) begin
            gnt_o[k]  = (state_q == CHECK);
            done_o[k] = (state_q == RESP);
         end
      end
      err_o       = (state_q == RESP) && err_q;
      flash_req_o = (state_q == ISSUE);
   end

   assign flash_addr_o = flash_addr_q;
   assign flash_op_o   = flash_op_q;

endmodule

// File: tb/tb_flash_ctrl_region_arb.sv
// Scoreboard bench for flash_ctrl_region_arb: directed region/arbitration cases plus random batches.
// Expected grants, completions and phy issues are queued from a reference model at stimulus time.
// Monitors and a phy responder pop the queues as the DUT produces events.
module tb_flash_ctrl_region_arb;
   localparam int NR = 2;
   localparam int NG = 4;
   localparam int AW = 16;
   localparam int TO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [NR-1:0]       req_i;
   logic [NR*AW-1:0]    addr_i;
   logic [NR*2-1:0]     op_i;
   logic [NR-1:0]       gnt_o, done_o;
   logic                err_o;
   logic                phase_i;
   logic [NG-1:0]       region_en_i;
   logic [NG*AW-1:0]    region_base_i, region_size_i;
   logic [NG*4-1:0]     region_attr_i;
   logic                flash_req_o;
   logic [AW-1:0]       flash_addr_o;
   logic [1:0]          flash_op_o;
   logic                flash_ack_i, flash_done_i, flash_err_i;

   flash_ctrl_region_arb #(
      .NumReq(NR), .NumRegions(NG), .AddrW(AW), .TimeoutCyc(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req_i), .addr_i(addr_i), .op_i(op_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
      .phase_i(phase_i),
      .region_en_i(region_en_i), .region_base_i(region_base_i),
      .region_size_i(region_size_i), .region_attr_i(region_attr_i),
      .flash_req_o(flash_req_o), .flash_addr_o(flash_addr_o), .flash_op_o(flash_op_o),
      .flash_ack_i(flash_ack_i), .flash_done_i(flash_done_i), .flash_err_i(flash_err_i)
   );

   typedef struct {int idx; bit err; int lat;} done_t;
   typedef struct {int a; int d; bit e; bit hang;} plan_t;
   typedef struct {logic [AW-1:0] addr; logic [1:0] op;} iss_t;

   int      gnt_q[$];
   done_t   done_q[$];
   plan_t   plan_q[$];
   iss_t    iss_q[$];

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   int done_cnt = 0;
   int gnt_cyc[NR];
   bit spur_en = 1'b0;
   int model_ptr = 0;
   logic [AW-1:0] last_addr = '0;
   logic [1:0]    last_op = '0;
   int  f_ack = -1, f_done = -1, f_err = -1;
   bit  f_hang = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic finish_sim();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   endtask

   // Reference permission model: first enabled region containing the page decides
   function automatic bit model_allowed(input logic [AW-1:0] addr, input logic [1:0] op);
      int b, s;
      logic [3:0] at;
      for (int r = 0; r < NG; r++) begin
         b  = int'(region_base_i[r*AW +: AW]);
         s  = int'(region_size_i[r*AW +: AW]);
         at = region_attr_i[r*4 +: 4];
         if (region_en_i[r] && int'(addr) >= b && int'(addr) < b + s)
            return (op != 2'd3) && (at[3] == phase_i) && at[op];
      end
      return 1'b0;
   endfunction

   task automatic set_region(input int r, input bit en, input logic [AW-1:0] base,
                             input logic [AW-1:0] size, input logic [3:0] attr);
      region_en_i[r]            = en;
      region_base_i[r*AW +: AW] = base;
      region_size_i[r*AW +: AW] = size;
      region_attr_i[r*4 +: 4]   = attr;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] addr, input logic [1:0] op);
      addr_i[k*AW +: AW] = addr;
      op_i[k*2 +: 2]     = op;
   endtask

   // Grant / completion monitor
   always @(negedge clk) begin
      int    k;
      done_t e;
      if (rst_n) begin
         if (gnt_o != '0) begin
            if (gnt_q.size() == 0) check_eq("gnt_unexpected", gnt_o, 0);
            else begin
               k = gnt_q.pop_front();
               check_eq("gnt", gnt_o, longint'(1) << k);
               gnt_cyc[k] = cyc;
            end
         end
         if (done_o != '0) begin
            if (done_q.size() == 0) check_eq("done_unexpected", done_o, 0);
            else begin
               e = done_q.pop_front();
               check_eq("done", done_o, longint'(1) << e.idx);
               check_eq("err", err_o, e.err);
               check_eq("gnt_to_done_latency", cyc - gnt_cyc[e.idx], e.lat);
            end
            done_cnt++;
         end
      end
   end

   // Phy model serving one issued op according to the queued plan
   task automatic serve();
      plan_t p;
      iss_t  x;
      flash_done_i = 1'b0;
      flash_err_i  = 1'b0;
      if (plan_q.size() == 0 || iss_q.size() == 0) begin
         check_eq("flash_req_unexpected", flash_req_o, 0);
         return;
      end
      p = plan_q.pop_front();
      x = iss_q.pop_front();
      check_eq("flash_addr", flash_addr_o, x.addr);
      check_eq("flash_op", flash_op_o, x.op);
      for (int n = 0; n <= p.a; n++) begin
         check_eq("flash_req_held", flash_req_o, 1);
         flash_ack_i = (n == p.a);
         @(negedge clk);
      end
      flash_ack_i = 1'b0;
      check_eq("flash_req_drop", flash_req_o, 0);
      if (p.hang) return;
      repeat (p.d) @(negedge clk);
      flash_done_i = 1'b1;
      flash_err_i  = p.e;
      @(negedge clk);
      flash_done_i = 1'b0;
      flash_err_i  = 1'b0;
   endtask

   initial begin
      flash_ack_i  = 1'b0;
      flash_done_i = 1'b0;
      flash_err_i  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && flash_req_o) serve();
         else begin
            flash_ack_i = 1'b0;
            if (spur_en) begin
               flash_done_i = ($urandom_range(0, 3) == 0);
               flash_err_i  = 1'($urandom_range(0, 1));
            end else begin
               flash_done_i = 1'b0;
               flash_err_i  = 1'b0;
            end
         end
      end
   end

   // Predict the grant order and responses for all requesters in mask, then drive them
   task automatic run_batch(input logic [NR-1:0] mask);
      logic [NR-1:0] pend;
      int    p, k, target;
      bit    ok;
      plan_t pl;
      iss_t  ix;
      done_t de;
      pend = mask;
      p    = model_ptr;
      while (pend != '0) begin
         k = p;
         while (!pend[k]) k = (k + 1) % NR;
         gnt_q.push_back(k);
         ok = model_allowed(addr_i[k*AW +: AW], op_i[k*2 +: 2]);
         if (ok) begin
            pl.a    = (f_ack  >= 0) ? f_ack  : int'($urandom_range(0, 3));
            pl.d    = (f_done >= 0) ? f_done : int'($urandom_range(0, 3));
            pl.e    = (f_err  >= 0) ? f_err[0] : 1'($urandom_range(0, 1));
            pl.hang = f_hang;
            if (f_hang) begin
               pl.d = TO - 1;
               pl.e = 1'b1;
            end
            plan_q.push_back(pl);
            ix.addr = addr_i[k*AW +: AW];
            ix.op   = op_i[k*2 +: 2];
            iss_q.push_back(ix);
            last_addr = ix.addr;
            last_op   = ix.op;
            de = '{idx: k, err: pl.e, lat: 3 + pl.a + pl.d};
         end else begin
            de = '{idx: k, err: 1'b1, lat: 1};
         end
         done_q.push_back(de);
         pend[k] = 1'b0;
         p = (k + 1) % NR;
      end
      model_ptr = p;
      target = done_cnt + $countones(mask);
      req_i = mask;
      for (int t = 0; t < 400 && done_cnt < target; t++) begin
         @(negedge clk);
         for (int j = 0; j < NR; j++) begin
            if (gnt_o[j]) begin
               req_i[j] = 1'b0;
               addr_i[j*AW +: AW] = AW'($urandom);
               op_i[j*2 +: 2]     = 2'($urandom);
            end
         end
      end
      if (done_cnt < target) begin
         check_eq("batch_timeout", done_cnt, target);
         finish_sim();
      end
      repeat (2) @(negedge clk);
      check_eq("flash_addr_hold", flash_addr_o, last_addr);
      check_eq("flash_op_hold", flash_op_o, last_op);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int r, b, s;
      r = $urandom_range(0, NG - 1);
      b = int'(region_base_i[r*AW +: AW]);
      s = int'(region_size_i[r*AW +: AW]);
      case ($urandom_range(0, 2))
         0:       return AW'(b + int'($urandom_range(0, s)));
         1:       return AW'(b + s - 1 + int'($urandom_range(0, 2)) - 1);
         default: return AW'($urandom);
      endcase
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_gnt"}, gnt_o, 0);
      check_eq({tag, "_done"}, done_o, 0);
      check_eq({tag, "_err"}, err_o, 0);
      check_eq({tag, "_flash_req"}, flash_req_o, 0);
      check_eq({tag, "_flash_addr"}, flash_addr_o, 0);
      check_eq({tag, "_flash_op"}, flash_op_o, 0);
   endtask

   initial begin
      bit saw;
      rst_n = 1'b0;
      req_i = '0;
      addr_i = '0;
      op_i = '0;
      phase_i = 1'b1;
      region_en_i = '0;
      region_base_i = '0;
      region_size_i = '0;
      region_attr_i = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("post_reset");

      // Region 0: pages 0x0100..0x010F, read only, phase 1
      set_region(0, 1'b1, 16'h0100, 16'h0010, 4'b1001);
      f_ack = 0; f_done = 0; f_err = 0;
      set_req(0, 16'h0100, 2'd0);
      set_req(1, 16'h010F, 2'd0);
      run_batch(2'b11);
      set_req(0, 16'h0104, 2'd0);
      set_req(1, 16'h0108, 2'd0);
      run_batch(2'b11);

      // Past the region end, missing permission, wrong phase
      set_req(0, 16'h0110, 2'd0);
      run_batch(2'b01);
      set_req(1, 16'h0100, 2'd1);
      run_batch(2'b10);
      phase_i = 1'b0;
      set_req(0, 16'h0100, 2'd0);
      run_batch(2'b01);
      phase_i = 1'b1;

      // Overlap: region 0 (rd) shadows region 1 (rd+prog) at 0x0200
      set_region(0, 1'b1, 16'h0200, 16'h0010, 4'b1001);
      set_region(1, 1'b1, 16'h0200, 16'h0100, 4'b1011);
      set_req(0, 16'h0200, 2'd1);
      set_req(1, 16'h0250, 2'd1);
      run_batch(2'b11);

      // Slow phy ack and error on done
      f_ack = 3; f_done = 1; f_err = 1;
      set_req(0, 16'h0250, 2'd0);
      run_batch(2'b01);

      // Region reaching past the top does not wrap; empty region never matches; reserved op
      set_region(2, 1'b1, 16'hFFF0, 16'h0020, 4'b1111);
      set_region(3, 1'b1, 16'h0000, 16'h0000, 4'b1111);
      f_ack = 0; f_done = 0; f_err = 0;
      set_req(0, 16'hFFFF, 2'd2);
      set_req(1, 16'h0005, 2'd0);
      run_batch(2'b11);
      set_req(0, 16'hFFF5, 2'd3);
      set_req(1, 16'h02FF, 2'd2);
      run_batch(2'b11);
      set_req(0, 16'h0300, 2'd0);
      set_req(1, 16'h02FF, 2'd0);
      run_batch(2'b11);

      // Random traffic with spurious phy done pulses while idle
      spur_en = 1'b1;
      f_ack = -1; f_done = -1; f_err = -1;
      for (int it = 0; it < 200; it++) begin
         if (it % 40 == 0) begin
            for (int r = 0; r < NG; r++)
               set_region(r, 1'($urandom_range(0, 3) != 0), AW'($urandom),
                          AW'($urandom_range(0, 16'h0400)), 4'($urandom));
         end
         phase_i = 1'($urandom_range(0, 1));
         for (int k = 0; k < NR; k++) set_req(k, rand_addr(), 2'($urandom));
         run_batch(NR'($urandom_range(0, 3)));
      end
      spur_en = 1'b0;
      repeat (2) @(negedge clk);

      // Reset while waiting for the phy: op is abandoned without done
      set_region(0, 1'b1, 16'h0000, 16'hFFFF, 4'b1111);
      phase_i = 1'b1;
      gnt_q.push_back(1);
      plan_q.push_back('{a: 0, d: 0, e: 1'b0, hang: 1'b1});
      iss_q.push_back('{addr: 16'h0010, op: 2'd0});
      set_req(1, 16'h0010, 2'd0);
      req_i = 2'b10;
      saw = 1'b0;
      for (int t = 0; t < 50 && !(saw && !flash_req_o); t++) begin
         @(negedge clk);
         if (gnt_o[1]) req_i[1] = 1'b0;
         if (flash_req_o) saw = 1'b1;
      end
      check_eq("reached_wait", saw && !flash_req_o, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("mid_op_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_ptr = 0;
      last_addr = '0;
      last_op = '0;
      f_ack = 0; f_done = 0; f_err = 0;
      set_req(0, 16'h0020, 2'd0);
      set_req(1, 16'h0030, 2'd0);
      run_batch(2'b11);

`ifdef FLASH_CTRL_REGION_ARB_TIMEOUT_EN
      f_ack = 1;
      f_hang = 1'b1;
      set_req(0, 16'h0040, 2'd0);
      run_batch(2'b01);
      f_hang = 1'b0;
`endif

      check_eq("gnt_q_drained", gnt_q.size(), 0);
      check_eq("done_q_drained", done_q.size(), 0);
      check_eq("plan_q_drained", plan_q.size(), 0);
      check_eq("iss_q_drained", iss_q.size(), 0);
      finish_sim();
   end

endmodule
